instr_queue: RTL and testbench

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue_if.sv | 38 +++
 rtl/instr_queue.sv | 77 +++++++
 tb/tb_instr_queue.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/instr_queue_if.sv
// Fetcher/decoder handshake bundle for the instruction queue.
interface instr_queue_if;
   logic        push_from_fetcher;
   logic [31:0] pc_from_fetcher;
   logic [31:0] instr_from_fetcher;
   logic        full_to_fetcher;
   logic        pop_from_dc;
   logic        clear_from_rob;
   logic        is_empty_to_dc;
   logic [31:0] pc_to_dc;
   logic [31:0] instr_to_dc;

   // Queue side.
   modport slave (
      input  push_from_fetcher,
      input  pc_from_fetcher,
      input  instr_from_fetcher,
      output full_to_fetcher,
      input  pop_from_dc,
      input  clear_from_rob,
      output is_empty_to_dc,
      output pc_to_dc,
      output instr_to_dc
   );

   // Fetcher / decoder / ROB side.
   modport master (
      output push_from_fetcher,
      output pc_from_fetcher,
      output instr_from_fetcher,
      input  full_to_fetcher,
      output pop_from_dc,
      output clear_from_rob,
      input  is_empty_to_dc,
      input  pc_to_dc,
      input  instr_to_dc
   );
endinterface

// File: rtl/instr_queue.sv
// Circular first-word-fall-through queue of {pc, instr} between fetch and decode.
// Validity is defined only by head/tail/count; storage is never cleared.
module instr_queue #(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   instr_queue_if.slave  q
);

   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] head_q, head_d;
   logic [ADDR_WIDTH-1:0] tail_q, tail_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [63:0]           mem_q [DEPTH];
   logic [63:0]           head_entry;
   logic                  full, empty;
   logic                  push_ok, pop_ok;

   // Status comes from the registered count only, so no input reaches an output.
   always_comb begin
      full       = (count_q == DEPTH_CNT);
      empty      = (count_q == '0);
      head_entry = mem_q[head_q];
   end

   // Accept/flush decisions and next pointer/count values; flush wins over everything.
   always_comb begin
      push_ok = rst && q.push_from_fetcher && !full  && !q.clear_from_rob;
      pop_ok  = rst && q.pop_from_dc       && !empty && !q.clear_from_rob;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (q.clear_from_rob) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok) tail_d = tail_q + 1'b1;
         if (pop_ok)  head_d = head_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are meaningful only between head and tail.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[tail_q] <= {q.pc_from_fetcher, q.instr_from_fetcher};
   end

   // Head entry falls through; forced to zero when nothing is valid.
   always_comb begin
      q.full_to_fetcher = full;
      q.is_empty_to_dc  = empty;
      q.pc_to_dc        = empty ? 32'h0 : head_entry[63:32];
      q.instr_to_dc     = empty ? 32'h0 : head_entry[31:0];
   end

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue.
module tb_instr_queue;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   instr_queue_if qif ();

   instr_queue #(.DEPTH(16), .ADDR_WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .q   (qif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_instr(input logic [31:0] pc);
      return {16'hC0DE, pc[15:0]};
   endfunction

   task automatic idle();
      qif.push_from_fetcher  = 1'b0;
      qif.pc_from_fetcher    = 32'h0;
      qif.instr_from_fetcher = 32'h0;
      qif.pop_from_dc        = 1'b0;
      qif.clear_from_rob     = 1'b0;
   endtask

   // One clock with the given inputs; returns 1ns after the edge with inputs idle.
   task automatic step(input logic push, input logic [31:0] pc, input logic pop, input logic clr);
      qif.push_from_fetcher  = push;
      qif.pc_from_fetcher    = pc;
      qif.instr_from_fetcher = exp_instr(pc);
      qif.pop_from_dc        = pop;
      qif.clear_from_rob     = clr;
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b0;
      #13;
      n_cmp++; if (qif.is_empty_to_dc !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", qif.is_empty_to_dc); end
      n_cmp++; if (qif.full_to_fetcher !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", qif.full_to_fetcher); end
      n_cmp++; if (qif.pc_to_dc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", qif.pc_to_dc); end
      // Inputs ignored while in reset.
      step(1'b1, 32'h1234, 1'b0, 1'b0);
      n_cmp++; if (qif.is_empty_to_dc !== 1'b1) begin n_err++; $display("FAIL reset_push_ignored got=%b exp=1", qif.is_empty_to_dc); end
      #3 rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_first_push();
      step(1'b1, 32'h0, 1'b0, 1'b0);
      qif.instr_from_fetcher = 32'h0;
      n_cmp++; if (qif.is_empty_to_dc !== 1'b0) begin n_err++; $display("FAIL first_empty got=%b exp=0", qif.is_empty_to_dc); end
      n_cmp++; if (qif.pc_to_dc !== 32'h0) begin n_err++; $display("FAIL first_pc got=%h exp=0", qif.pc_to_dc); end
      n_cmp++; if (qif.instr_to_dc !== 32'hC0DE_0000) begin n_err++; $display("FAIL first_instr got=%h exp=c0de0000", qif.instr_to_dc); end
      step(1'b0, 32'h0, 1'b1, 1'b0);
      n_cmp++; if (qif.is_empty_to_dc !== 1'b1) begin n_err++; $display("FAIL first_drain got=%b exp=1", qif.is_empty_to_dc); end
   endtask

   // Also checks no same-cycle bypass and the literal instruction word 0x513.
   task automatic test_literal_instr();
      qif.push_from_fetcher  = 1'b1;
      qif.pc_from_fetcher    = 32'h0;
      qif.instr_from_fetcher = 32'h0000_0513;
      #1;
      n_cmp++; if (qif.is_empty_to_dc !== 1'b1) begin n_err++; $display("FAIL no_bypass_empty got=%b exp=1", qif.is_empty_to_dc); end
      @(posedge clk); #1; idle();
      n_cmp++; if (qif.instr_to_dc !== 32'h0000_0513) begin n_err++; $display("FAIL literal_instr got=%h exp=00000513", qif.instr_to_dc); end
      step(1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 16; i++) step(1'b1, 32'(i*4), 1'b0, 1'b0);
      n_cmp++; if (qif.full_to_fetcher !== 1'b1) begin n_err++; $display("FAIL fill_full got=%b exp=1", qif.full_to_fetcher); end
      step(1'b1, 32'h40, 1'b0, 1'b0);
      n_cmp++; if (qif.full_to_fetcher !== 1'b1) begin n_err++; $display("FAIL drop_full got=%b exp=1", qif.full_to_fetcher); end
      for (int i = 0; i < 16; i++) begin
         n_cmp++; if (qif.pc_to_dc !== 32'(i*4)) begin n_err++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, qif.pc_to_dc, 32'(i*4)); end
         n_cmp++; if (qif.instr_to_dc !== exp_instr(32'(i*4))) begin n_err++; $display("FAIL drain_instr[%0d] got=%h exp=%h", i, qif.instr_to_dc, exp_instr(32'(i*4))); end
         step(1'b0, 32'h0, 1'b1, 1'b0);
      end
      n_cmp++; if (qif.is_empty_to_dc !== 1'b1) begin n_err++; $display("FAIL drain_empty got=%b exp=1", qif.is_empty_to_dc); end
      n_cmp++; if (qif.pc_to_dc !== 32'h0) begin n_err++; $display("FAIL drain_pc_zero got=%h exp=0", qif.pc_to_dc); end
      n_cmp++; if (qif.instr_to_dc !== 32'h0) begin n_err++; $display("FAIL drain_instr_zero got=%h exp=0", qif.instr_to_dc); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc;
      for (int i = 0; i < 16; i++) step(1'b1, 32'(i*4), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 32'h100 + 32'(i*4), 1'b0, 1'b0);
      n_cmp++; if (qif.full_to_fetcher !== 1'b1) begin n_err++; $display("FAIL wrap_full got=%b exp=1", qif.full_to_fetcher); end
      for (int i = 0; i < 16; i++) begin
         exp_pc = (i < 6) ? 32'h28 + 32'(i*4) : 32'h100 + 32'((i-6)*4);
         n_cmp++; if (qif.pc_to_dc !== exp_pc) begin n_err++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", i, qif.pc_to_dc, exp_pc); end
         n_cmp++; if (qif.instr_to_dc !== exp_instr(exp_pc)) begin n_err++; $display("FAIL wrap_instr[%0d] got=%h exp=%h", i, qif.instr_to_dc, exp_instr(exp_pc)); end
         step(1'b0, 32'h0, 1'b1, 1'b0);
      end
      n_cmp++; if (qif.is_empty_to_dc !== 1'b1) begin n_err++; $display("FAIL wrap_empty got=%b exp=1", qif.is_empty_to_dc); end
   endtask

   task automatic test_clear_priority();
      for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + 32'(i*4), 1'b0, 1'b0);
      step(1'b1, 32'h300, 1'b1, 1'b1);
      n_cmp++; if (qif.is_empty_to_dc !== 1'b1) begin n_err++; $display("FAIL clear_empty got=%b exp=1", qif.is_empty_to_dc); end
      n_cmp++; if (qif.pc_to_dc !== 32'h0) begin n_err++; $display("FAIL clear_pc got=%h exp=0", qif.pc_to_dc); end
      step(1'b1, 32'h400, 1'b0, 1'b0);
      n_cmp++; if (qif.pc_to_dc !== 32'h400) begin n_err++; $display("FAIL clear_next_pc got=%h exp=400", qif.pc_to_dc); end
      step(1'b0, 32'h0, 1'b1, 1'b0);
      n_cmp++; if (qif.is_empty_to_dc !== 1'b1) begin n_err++; $display("FAIL clear_alone got=%b exp=1", qif.is_empty_to_dc); end
   endtask

   task automatic test_back_to_back();
      step(1'b1, 32'h500, 1'b1, 1'b0);
      n_cmp++; if (qif.is_empty_to_dc !== 1'b0) begin n_err++; $display("FAIL empty_pushpop_empty got=%b exp=0", qif.is_empty_to_dc); end
      n_cmp++; if (qif.pc_to_dc !== 32'h500) begin n_err++; $display("FAIL empty_pushpop_pc got=%h exp=500", qif.pc_to_dc); end
      step(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b1, 32'h600 + 32'(i*4), 1'b0, 1'b0);
      step(1'b1, 32'h7F0, 1'b1, 1'b0);
      n_cmp++; if (qif.full_to_fetcher !== 1'b0) begin n_err++; $display("FAIL full_pushpop_full got=%b exp=0", qif.full_to_fetcher); end
      for (int i = 1; i < 16; i++) begin
         n_cmp++; if (qif.pc_to_dc !== 32'h600 + 32'(i*4)) begin n_err++; $display("FAIL full_pushpop_pc[%0d] got=%h exp=%h", i, qif.pc_to_dc, 32'h600 + 32'(i*4)); end
         step(1'b0, 32'h0, 1'b1, 1'b0);
      end
      n_cmp++; if (qif.is_empty_to_dc !== 1'b1) begin n_err++; $display("FAIL full_pushpop_dropped got=%b exp=1", qif.is_empty_to_dc); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 7; i++) step(1'b1, 32'h800 + 32'(i*4), 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (qif.is_empty_to_dc !== 1'b1) begin n_err++; $display("FAIL async_empty got=%b exp=1", qif.is_empty_to_dc); end
      n_cmp++; if (qif.pc_to_dc !== 32'h0) begin n_err++; $display("FAIL async_pc got=%h exp=0", qif.pc_to_dc); end
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 32'h900, 1'b0, 1'b0);
      n_cmp++; if (qif.pc_to_dc !== 32'h900) begin n_err++; $display("FAIL post_reset_pc got=%h exp=900", qif.pc_to_dc); end
      step(1'b0, 32'h0, 1'b1, 1'b0);
      n_cmp++; if (qif.is_empty_to_dc !== 1'b1) begin n_err++; $display("FAIL post_reset_pop got=%b exp=1", qif.is_empty_to_dc); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_first_push();
      test_literal_instr();
      test_fill_drain();
      test_wrap();
      test_clear_priority();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
